// File: rtl/axi_lite_decoder_pkg.sv
// soc_pkg: address map, AXI response codes and decoder FSM states.
// Shared by the AXI4-lite 1:2 decoder slice.
package soc_pkg;

  localparam logic [31:0] ADDR_MEM_BASE    = 32'h0000_0000;
  localparam logic [31:0] ADDR_MEM_SIZE    = 32'h0001_8000;
  localparam logic [31:0] ADDR_PERIPH_BASE = 32'h1000_0000;
  localparam logic [31:0] ADDR_PERIPH_SIZE = 32'h0000_1000;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    R_IDLE, R_FWD, R_WAIT, R_RESP, R_ERR
  } rd_state_t;

  typedef enum logic [2:0] {
    W_IDLE, W_FWD, W_WAIT, W_RESP, W_ERR
  } wr_state_t;

  typedef struct packed {
    logic mem;
    logic periph;
    logic none;
  } sel_t;

  // 33-bit offset: below base wraps past 2^32, so it never hits
  function automatic logic in_region(
    input logic [31:0] a,
    input logic [31:0] base,
    input logic [31:0] size
  );
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, base};
    return off < {1'b0, size};
  endfunction

endpackage

// File: rtl/axi_lite_decoder_if.sv
// axi_interf: AXI4-lite bundle, 32-bit address and data.
// master drives requests, slave drives responses.
interface axi_interf;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_decoder_addr_decode.sv
// axi_addr_decode: one-hot region select for a 32-bit address.
// Memory wins over peripheral if the regions ever overlap.
module axi_addr_decode
  import soc_pkg::*;
#(
  parameter logic [31:0] MEM_BASE    = ADDR_MEM_BASE,
  parameter logic [31:0] MEM_SIZE    = ADDR_MEM_SIZE,
  parameter logic [31:0] PERIPH_BASE = ADDR_PERIPH_BASE,
  parameter logic [31:0] PERIPH_SIZE = ADDR_PERIPH_SIZE
) (
  input  logic [31:0] i_addr,
  output sel_t        o_sel
);
  logic w_mem;
  logic w_per;

  assign w_mem = in_region(i_addr, MEM_BASE, MEM_SIZE);
  assign w_per = in_region(i_addr, PERIPH_BASE, PERIPH_SIZE);

  assign o_sel.mem    = w_mem;
  assign o_sel.periph = !w_mem && w_per;
  assign o_sel.none   = !w_mem && !w_per;
endmodule

// File: rtl/axi_lite_decoder.sv
// axi_lite_decoder: registered AXI4-lite 1-master to 2-slave router.
// Unmapped addresses are answered locally with DECERR.
module axi_lite_decoder
  import soc_pkg::*;
#(
  parameter logic [31:0] MEM_BASE    = ADDR_MEM_BASE,
  parameter logic [31:0] MEM_SIZE    = ADDR_MEM_SIZE,
  parameter logic [31:0] PERIPH_BASE = ADDR_PERIPH_BASE,
  parameter logic [31:0] PERIPH_SIZE = ADDR_PERIPH_SIZE
) (
  input logic        clk,
  input logic        resetn,
  axi_interf.slave   s_axi,
  axi_interf.master  m_mem,
  axi_interf.master  m_periph
);
  rd_state_t   r_rst, w_rnxt;
  wr_state_t   r_wst, w_wnxt;
  sel_t        w_ar_sel, w_aw_sel;
  logic [31:0] r_araddr, r_awaddr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_rresp, r_bresp;
  logic        r_rmem, r_rper, r_wmem, r_wper;
  logic        r_aw_got, r_w_got, r_aw_pend, r_w_pend;
  logic        w_ar_hs, w_aw_hs, w_w_hs, w_wmapped;
  logic        w_m_arready, w_m_rvalid, w_m_awready;
  logic        w_m_wready, w_m_bvalid;
  logic [31:0] w_m_rdata;
  logic [1:0]  w_m_rresp, w_m_bresp;
  logic        w_unused;

  assign w_unused = ^{s_axi.awprot, s_axi.arprot};

  axi_addr_decode #(
    .MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE),
    .PERIPH_BASE(PERIPH_BASE), .PERIPH_SIZE(PERIPH_SIZE)
  ) u_ar_dec (.i_addr(s_axi.araddr), .o_sel(w_ar_sel));

  axi_addr_decode #(
    .MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE),
    .PERIPH_BASE(PERIPH_BASE), .PERIPH_SIZE(PERIPH_SIZE)
  ) u_aw_dec (.i_addr(s_axi.awaddr), .o_sel(w_aw_sel));

  assign w_ar_hs = s_axi.arvalid && (r_rst == R_IDLE);
  assign w_aw_hs = s_axi.awvalid && (r_wst == W_IDLE) && !r_aw_got;
  assign w_w_hs  = s_axi.wvalid && (r_wst == W_IDLE) && !r_w_got;
  assign w_wmapped = w_aw_hs ? !w_aw_sel.none : (r_wmem || r_wper);

  assign w_m_arready = r_rmem ? m_mem.arready : m_periph.arready;
  assign w_m_rvalid  = r_rmem ? m_mem.rvalid  : m_periph.rvalid;
  assign w_m_rdata   = r_rmem ? m_mem.rdata   : m_periph.rdata;
  assign w_m_rresp   = r_rmem ? m_mem.rresp   : m_periph.rresp;
  assign w_m_awready = r_wmem ? m_mem.awready : m_periph.awready;
  assign w_m_wready  = r_wmem ? m_mem.wready  : m_periph.wready;
  assign w_m_bvalid  = r_wmem ? m_mem.bvalid  : m_periph.bvalid;
  assign w_m_bresp   = r_wmem ? m_mem.bresp   : m_periph.bresp;

  // read FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rst <= R_IDLE;
    else         r_rst <= w_rnxt;
  end

  // read FSM next state
  always_comb begin
    w_rnxt = r_rst;
    case (r_rst)
      R_IDLE: if (w_ar_hs) w_rnxt = w_ar_sel.none ? R_ERR : R_FWD;
      R_FWD:  if (w_m_arready) w_rnxt = R_WAIT;
      R_WAIT: if (w_m_rvalid) w_rnxt = R_RESP;
      R_RESP, R_ERR: if (s_axi.rready) w_rnxt = R_IDLE;
      default: w_rnxt = R_IDLE;
    endcase
  end

  // read datapath: latch request, then the response to relay
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_araddr <= '0;
      r_rmem   <= 1'b0;
      r_rper   <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else if (w_ar_hs) begin
      r_araddr <= s_axi.araddr;
      r_rmem   <= w_ar_sel.mem;
      r_rper   <= w_ar_sel.periph;
      if (w_ar_sel.none) begin
        r_rdata <= '0;
        r_rresp <= DECERR;
      end
    end else if (r_rst == R_WAIT && w_m_rvalid) begin
      r_rdata <= w_m_rdata;
      r_rresp <= w_m_rresp;
    end
  end

  // write FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_wst <= W_IDLE;
    else         r_wst <= w_wnxt;
  end

  // write FSM next state
  always_comb begin
    w_wnxt = r_wst;
    case (r_wst)
      W_IDLE:
        if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs))
          w_wnxt = w_wmapped ? W_FWD : W_ERR;
      W_FWD:
        if ((!r_aw_pend || w_m_awready) && (!r_w_pend || w_m_wready))
          w_wnxt = W_WAIT;
      W_WAIT: if (w_m_bvalid) w_wnxt = W_RESP;
      W_RESP, W_ERR: if (s_axi.bready) w_wnxt = W_IDLE;
      default: w_wnxt = W_IDLE;
    endcase
  end

  // write datapath: collect AW/W beats, track downstream handshakes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wmem    <= 1'b0;
      r_wper    <= 1'b0;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_aw_pend <= 1'b0;
      r_w_pend  <= 1'b0;
      r_bresp   <= '0;
    end else begin
      if (w_aw_hs) begin
        r_awaddr <= s_axi.awaddr;
        r_wmem   <= w_aw_sel.mem;
        r_wper   <= w_aw_sel.periph;
        r_aw_got <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata <= s_axi.wdata;
        r_wstrb <= s_axi.wstrb;
        r_w_got <= 1'b1;
      end
      if (r_wst == W_FWD) begin
        if (w_m_awready) r_aw_pend <= 1'b0;
        if (w_m_wready)  r_w_pend  <= 1'b0;
      end
      if (r_wst == W_WAIT && w_m_bvalid) r_bresp <= w_m_bresp;
      if (r_wst == W_IDLE && w_wnxt != W_IDLE) begin
        r_aw_got  <= 1'b0;
        r_w_got   <= 1'b0;
        r_aw_pend <= 1'b1;
        r_w_pend  <= 1'b1;
        if (w_wnxt == W_ERR) r_bresp <= DECERR;
      end
    end
  end

  assign s_axi.arready = (r_rst == R_IDLE);
  assign s_axi.rvalid  = (r_rst == R_RESP) || (r_rst == R_ERR);
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.awready = (r_wst == W_IDLE) && !r_aw_got;
  assign s_axi.wready  = (r_wst == W_IDLE) && !r_w_got;
  assign s_axi.bvalid  = (r_wst == W_RESP) || (r_wst == W_ERR);
  assign s_axi.bresp   = r_bresp;

  assign m_mem.araddr  = r_araddr;
  assign m_mem.arprot  = 3'b000;
  assign m_mem.arvalid = (r_rst == R_FWD) && r_rmem;
  assign m_mem.rready  = (r_rst == R_WAIT) && r_rmem;
  assign m_mem.awaddr  = r_awaddr;
  assign m_mem.awprot  = 3'b000;
  assign m_mem.awvalid = (r_wst == W_FWD) && r_aw_pend && r_wmem;
  assign m_mem.wdata   = r_wdata;
  assign m_mem.wstrb   = r_wstrb;
  assign m_mem.wvalid  = (r_wst == W_FWD) && r_w_pend && r_wmem;
  assign m_mem.bready  = (r_wst == W_WAIT) && r_wmem;

  assign m_periph.araddr  = r_araddr;
  assign m_periph.arprot  = 3'b000;
  assign m_periph.arvalid = (r_rst == R_FWD) && r_rper;
  assign m_periph.rready  = (r_rst == R_WAIT) && r_rper;
  assign m_periph.awaddr  = r_awaddr;
  assign m_periph.awprot  = 3'b000;
  assign m_periph.awvalid = (r_wst == W_FWD) && r_aw_pend && r_wper;
  assign m_periph.wdata   = r_wdata;
  assign m_periph.wstrb   = r_wstrb;
  assign m_periph.wvalid  = (r_wst == W_FWD) && r_w_pend && r_wper;
  assign m_periph.bready  = (r_wst == W_WAIT) && r_wper;
endmodule

// File: doc/axi_lite_decoder.md
# axi_lite_decoder

AXI4-lite 1-master-to-2-slave address decoder sitting between the CPU's AXI4-lite master port and the SoC slaves: the unified ROM/RAM memory on the memory port and the peripheral region on the peripheral port. It registers each request, routes it by address, relays the slave's response back, and answers unmapped addresses itself with DECERR. There is at most one read and one write in flight, and the read and write paths are independent.

## Interface
- MEM_BASE, 32'h0000_0000, memory region base (covers ROM and RAM).
- MEM_SIZE, 32'h0001_8000, memory region length in bytes (64 KiB ROM + 32 KiB RAM).
- PERIPH_BASE, 32'h1000_0000, peripheral region base.
- PERIPH_SIZE, 32'h0000_1000, peripheral region length in bytes.
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_axi  axi_interf.slave  —  upstream port from the CPU master.
- m_mem  axi_interf.master  —  downstream port to the memory slave.
- m_periph  axi_interf.master  —  downstream port to the peripheral slave.

## Operation
- Region hit when `base <= addr < base + size`, using a 33-bit compare so the end address cannot wrap. Memory is checked before peripheral. An address in neither region is unmapped.
- awprot/arprot are ignored. araddr/awaddr are forwarded unmodified.
- Read FSM, states R_IDLE, R_FWD, R_WAIT, R_RESP, R_ERR:
  - R_IDLE: s.arready=1. On arvalid&&arready, latch araddr and the selected port, then go to R_FWD, or to R_ERR if unmapped.
  - R_FWD: the selected m.arvalid=1 with the latched address. On m.arready, go to R_WAIT.
  - R_WAIT: the selected m.rready=1. On m.rvalid, latch rdata/rresp and go to R_RESP.
  - R_RESP: s.rvalid=1 and rdata/rresp are held stable. On s.rready, go to R_IDLE.
  - R_ERR: s.rvalid=1, rdata=0, rresp=DECERR (2'b11). On s.rready, go to R_IDLE.
- Write FSM, states W_IDLE, W_FWD, W_WAIT, W_RESP, W_ERR:
  - W_IDLE: s.awready=1 and s.wready=1, each deasserting independently once its beat is latched. AW and W may arrive in either order or in the same cycle. Leave W_IDLE only when both are latched: go to W_FWD, or to W_ERR if unmapped.
  - W_FWD: assert m.awvalid and m.wvalid together. Each drops independently on its own ready. wdata/wstrb are held until the W handshake. Go to W_WAIT once both handshakes have completed.
  - W_WAIT: m.bready=1. On m.bvalid, latch bresp and go to W_RESP.
  - W_RESP: s.bvalid=1 with the latched bresp. On s.bready, go to W_IDLE.
  - W_ERR: s.bvalid=1, bresp=DECERR. The write is discarded and no downstream port is touched. On s.bready, go to W_IDLE.
- The non-selected downstream port sees all valids/readies at 0.
- A read and a write targeting the same slave in the same cycle are both forwarded; the slave arbitrates its own channels.

## Timing
- Reset values: s.arready=1, s.awready=1, s.wready=1. s.rvalid, s.bvalid and every m.*valid and m.*ready are 0. rdata, rresp and bresp are 0. FSMs are in R_IDLE/W_IDLE.
- Mapped read: m.arvalid rises 1 cycle after the s AR handshake. s.rvalid rises 1 cycle after the m R handshake. Added latency is 2 cycles over the slave.
- Unmapped read: s.rvalid rises 1 cycle after the AR handshake.
- Mapped write: m.awvalid and m.wvalid rise 1 cycle after the second of AW/W is latched. s.bvalid rises 1 cycle after the m B handshake.
- Outputs are registered. There is no combinational path from any input to any output.
- Reset asserted mid-transaction: both FSMs return to IDLE immediately and in-flight transactions are dropped. Downstream slaves are reset by the same resetn.

## Structure
- soc_pkg holds: the address-map constants (the MEM/PERIPH defaults), an axi_resp_t enum (OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11), and the rd_state_t/wr_state_t typedefs.
- One combinational sub-module, axi_addr_decode: 32-bit address in, one-hot {mem, periph, none} out. It is instantiated twice, once for AR and once for AW.

## Test plan
- Read 0x0000_0010 while the memory slave returns 0xDEADBEEF/OKAY -> s.rdata=0xDEADBEEF, rresp=00; m_periph stays idle throughout.
- Write 0x0001_0004, wdata 0x12345678, wstrb 4'b0011, with W issued 3 cycles before AW -> m_mem receives the same data/strobe and bresp=00 is returned; a follow-up read returns 0x????5678 per the memory model.
- Read 0x1000_0ffc versus 0x1000_1000 -> the first is routed to m_periph; the second gets rresp=DECERR with rdata=0, and no downstream arvalid is asserted.
- Write 0x2000_0000 -> bresp=DECERR 1 cycle after both beats are latched; no downstream awvalid/wvalid.
- Simultaneous read of 0x0 and write of 0x0001_0000, with s.rready and s.bready held low for 5 cycles -> both responses stay stable until accepted and no new AR/AW is accepted meanwhile.
- Assert resetn low during R_WAIT -> all outputs return to their reset values in the same cycle and a fresh read after release completes normally.
